// File: rtl/arp_reply_gen8.sv
// ARP reply generator: streams an Ethernet+ARP reply for requests aimed at local_ip.
// Optional macro ARP_PAD_EN pads the frame with zeros to the 60-byte Ethernet minimum.
module arp_reply_gen8 #(
   parameter int BYTE_SIZE = 8,
   parameter int MAC_SIZE  = 48,
   parameter int IP_SIZE   = 32,
   parameter int FRAME_LEN = 42
) (
   input  logic                 clk,
   input  logic                 sync_reset,
   input  logic                 arp_done,
   input  logic                 decode_valid,
   input  logic [15:0]          operation,
   input  logic [MAC_SIZE-1:0]  sender_hardware_address,
   input  logic [IP_SIZE-1:0]   sender_protocol_address,
   input  logic [IP_SIZE-1:0]   target_protocol_address,
   input  logic [MAC_SIZE-1:0]  local_mac,
   input  logic [IP_SIZE-1:0]   local_ip,
   output logic [BYTE_SIZE-1:0] tx_data,
   output logic                 tx_valid,
   output logic                 tx_sop,
   output logic                 tx_eop,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic [7:0]           drop_count
);

`ifdef ARP_PAD_EN
   localparam int FRAME_BYTES = 60;
`else
   localparam int FRAME_BYTES = FRAME_LEN;
`endif
   localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t                           state;
   logic [5:0]                       byte_cnt;
   logic [5:0]                       sel_idx;
   logic [MAC_SIZE-1:0]              req_mac;
   logic [MAC_SIZE-1:0]              our_mac;
   logic [IP_SIZE-1:0]               req_ip;
   logic [IP_SIZE-1:0]               our_ip;
   logic [FRAME_BYTES*BYTE_SIZE-1:0] frame;
   logic [BYTE_SIZE-1:0]             sel_byte;
   logic                             trigger;

   assign trigger = arp_done & decode_valid & (operation == 16'h0001) &
                    (target_protocol_address == local_ip);

   // Whole reply laid out MSB-first so byte index N sits N bytes below the top.
   always_comb begin
      frame = {req_mac, our_mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
               our_mac, our_ip, req_mac, req_ip
`ifdef ARP_PAD_EN
               , {(18*BYTE_SIZE){1'b0}}
`endif
               };
      sel_idx  = (state == SEND && byte_cnt != LAST_IDX) ? byte_cnt + 6'd1 : 6'd0;
      sel_byte = frame[(FRAME_BYTES - 1 - int'(sel_idx)) * BYTE_SIZE +: BYTE_SIZE];
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && trigger) begin
         req_mac <= sender_hardware_address;
         req_ip  <= sender_protocol_address;
         our_mac <= local_mac;
         our_ip  <= local_ip;
      end
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state      <= IDLE;
         byte_cnt   <= 6'd0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         tx_sop     <= 1'b0;
         tx_eop     <= 1'b0;
         busy       <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         // Any trigger outside IDLE, including the last-byte accept cycle, is dropped.
         if (trigger && state != IDLE && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
         case (state)
            IDLE: begin
               if (trigger) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               tx_data  <= sel_byte;
               tx_valid <= 1'b1;
               tx_sop   <= 1'b1;
               tx_eop   <= 1'b0;
               byte_cnt <= 6'd0;
               state    <= SEND;
            end
            SEND: begin
               if (tx_valid && tx_ready) begin
                  if (tx_eop) begin
                     tx_valid <= 1'b0;
                     tx_sop   <= 1'b0;
                     tx_eop   <= 1'b0;
                     busy     <= 1'b0;
                     byte_cnt <= 6'd0;
                     state    <= IDLE;
                  end else begin
                     byte_cnt <= byte_cnt + 6'd1;
                     tx_data  <= sel_byte;
                     tx_sop   <= 1'b0;
                     tx_eop   <= (byte_cnt + 6'd1 == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arp_reply_gen8.sv
// Self-checking bench for arp_reply_gen8: vector table, corner sequences and randomized frames.
module tb_arp_reply_gen8;

`ifdef ARP_PAD_EN
   localparam int EXP_LEN = 60;
`else
   localparam int EXP_LEN = 42;
`endif
   localparam logic [47:0] LMAC = 48'h02005E000001;
   localparam logic [31:0] LIP  = 32'hC0A80001;

   logic        clk, sync_reset, arp_done, decode_valid, tx_ready;
   logic [15:0] operation;
   logic [47:0] sender_hardware_address, local_mac;
   logic [31:0] sender_protocol_address, target_protocol_address, local_ip;
   logic [7:0]  tx_data, drop_count;
   logic        tx_valid, tx_sop, tx_eop, busy;

   int checks = 0;
   int failures = 0;
   int exp_drops = 0;
   int vcount = 0;
   bit frame_done = 0;
   logic [7:0] got_q[$];
   bit         got_sop[$];
   bit         got_eop[$];
   logic [7:0] exp_q[$];
   bit         prev_stall = 0;
   logic [9:0] prev_out;

   typedef struct {
      logic [15:0] op;
      logic        dv;
      logic [31:0] tpa;
      logic [47:0] smac;
      logic [31:0] spa;
      bit          reply;
   } vec_t;
   vec_t vecs[6];

   arp_reply_gen8 dut (
      .clk(clk), .sync_reset(sync_reset), .arp_done(arp_done), .decode_valid(decode_valid),
      .operation(operation), .sender_hardware_address(sender_hardware_address),
      .sender_protocol_address(sender_protocol_address),
      .target_protocol_address(target_protocol_address),
      .local_mac(local_mac), .local_ip(local_ip), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready), .busy(busy),
      .drop_count(drop_count));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: collects accepted bytes and verifies outputs hold during stalls.
   always @(negedge clk) begin
      if (prev_stall) begin
         check("stall_valid", {63'd0, tx_valid}, 64'd1);
         check("stall_hold", {54'd0, tx_sop, tx_eop, tx_data}, {54'd0, prev_out});
      end
      prev_stall = tx_valid && !tx_ready && !sync_reset;
      prev_out   = {tx_sop, tx_eop, tx_data};
      if (tx_valid) vcount++;
      if (tx_valid && tx_ready && !sync_reset) begin
         got_q.push_back(tx_data);
         got_sop.push_back(tx_sop);
         got_eop.push_back(tx_eop);
         if (tx_eop) frame_done = 1;
      end
   end

   task automatic clear_mon();
      got_q.delete();
      got_sop.delete();
      got_eop.delete();
      frame_done = 0;
      vcount = 0;
   endtask

   task automatic push_bytes(input logic [47:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
   endtask

   // Reference reply: fields laid out in wire order, then zero padding when enabled.
   task automatic model_frame(input logic [47:0] rmac, input logic [31:0] rip,
                              input logic [47:0] lmac, input logic [31:0] lip);
      exp_q.delete();
      push_bytes(rmac, 6);
      push_bytes(lmac, 6);
      push_bytes(48'h0806, 2);
      push_bytes(48'h0001, 2);
      push_bytes(48'h0800, 2);
      push_bytes(48'h06, 1);
      push_bytes(48'h04, 1);
      push_bytes(48'h0002, 2);
      push_bytes(lmac, 6);
      push_bytes({16'd0, lip}, 4);
      push_bytes(rmac, 6);
      push_bytes({16'd0, rip}, 4);
      while (exp_q.size() < EXP_LEN) exp_q.push_back(8'h00);
   endtask

   task automatic send_req(input logic [15:0] op, input logic dv, input logic [47:0] smac,
                           input logic [31:0] spa, input logic [31:0] tpa);
      @(posedge clk); #1;
      operation = op;
      decode_valid = dv;
      sender_hardware_address = smac;
      sender_protocol_address = spa;
      target_protocol_address = tpa;
      arp_done = 1;
      @(posedge clk); #1;
      arp_done = 0;
   endtask

   task automatic wait_frame(input bit rnd);
      bit ok;
      ok = 0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         tx_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         @(negedge clk);
         if (frame_done) begin
            ok = 1;
            break;
         end
      end
      check("frame_end_seen", {63'd0, ok}, 64'd1);
      @(posedge clk); #1;
      tx_ready = 1;
      check("idle_busy", {63'd0, busy}, 64'd0);
      check("idle_valid", {63'd0, tx_valid}, 64'd0);
   endtask

   task automatic check_frame(input string tag);
      int nsop, neop;
      nsop = 0;
      neop = 0;
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), {56'd0, got_q[i]}, {56'd0, exp_q[i]});
      foreach (got_sop[i]) nsop += int'(got_sop[i]);
      foreach (got_eop[i]) neop += int'(got_eop[i]);
      if (got_q.size() > 0) begin
         check({tag, "_sop_first"}, {63'd0, got_sop[0]}, 64'd1);
         check({tag, "_eop_last"}, {63'd0, got_eop[got_eop.size()-1]}, 64'd1);
      end
      check({tag, "_sop_count"}, nsop, 64'd1);
      check({tag, "_eop_count"}, neop, 64'd1);
   endtask

   initial begin
      logic [47:0] rmac, lmac;
      logic [31:0] rip, lip;
      int kind;

      vecs[0] = '{16'h0001, 1'b1, LIP, 48'h001122334455, 32'hC0A80002, 1'b1};
      vecs[1] = '{16'h0001, 1'b1, 32'hC0A80009, 48'h001122334455, 32'hC0A80002, 1'b0};
      vecs[2] = '{16'h0002, 1'b1, LIP, 48'h001122334455, 32'hC0A80002, 1'b0};
      vecs[3] = '{16'h0001, 1'b0, LIP, 48'h001122334455, 32'hC0A80002, 1'b0};
      vecs[4] = '{16'h0001, 1'b1, LIP, 48'hA1B2C3D4E5F6, 32'h0A000005, 1'b1};
      vecs[5] = '{16'h0101, 1'b1, LIP, 48'hA1B2C3D4E5F6, 32'h0A000005, 1'b0};

      sync_reset = 1; arp_done = 0; decode_valid = 0; tx_ready = 1; operation = 0;
      sender_hardware_address = 0; sender_protocol_address = 0; target_protocol_address = 0;
      local_mac = LMAC; local_ip = LIP;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {48'd0, tx_data, tx_valid, tx_sop, tx_eop, busy, 4'd0}, 64'd0);
      check("rst_drop", {56'd0, drop_count}, 64'd0);
      sync_reset = 0;

      // Reference request with latency check.
      clear_mon();
      model_frame(48'h001122334455, 32'hC0A80002, LMAC, LIP);
      send_req(16'h0001, 1'b1, 48'h001122334455, 32'hC0A80002, LIP);
      @(negedge clk);
      check("lat1_valid_busy", {62'd0, tx_valid, busy}, 64'd1);
      @(negedge clk);
      check("lat2_first", {54'd0, tx_valid, tx_sop, tx_data}, {54'd0, 2'b11, 8'h00});
      wait_frame(0);
      check_frame("ref");
      if (got_q.size() >= 22)
         check("ref_bytes20_21", {48'd0, got_q[20], got_q[21]}, 64'h0002);
      if (got_q.size() >= 42)
         check("ref_tail", {32'd0, got_q[38], got_q[39], got_q[40], got_q[41]}, 64'hC0A80002);

      // Table of single requests with tx_ready held high.
      for (int v = 0; v < 6; v++) begin
         clear_mon();
         model_frame(vecs[v].smac, vecs[v].spa, LMAC, LIP);
         send_req(vecs[v].op, vecs[v].dv, vecs[v].smac, vecs[v].spa, vecs[v].tpa);
         if (vecs[v].reply) begin
            wait_frame(0);
            check_frame($sformatf("vec%0d", v));
         end else begin
            repeat (70) @(negedge clk);
            check($sformatf("vec%0d_no_valid", v), vcount, 64'd0);
            check($sformatf("vec%0d_busy", v), {63'd0, busy}, 64'd0);
         end
         check($sformatf("vec%0d_drop", v), {56'd0, drop_count}, exp_drops);
      end

      // Same reference request with a stalling sink and local address changing mid-frame.
      clear_mon();
      model_frame(48'h001122334455, 32'hC0A80002, LMAC, LIP);
      send_req(16'h0001, 1'b1, 48'h001122334455, 32'hC0A80002, LIP);
      local_mac = 48'hDEADBEEF0000;
      local_ip  = 32'h01020304;
      wait_frame(1);
      check_frame("stall");
      local_mac = LMAC;
      local_ip  = LIP;

      // Second request mid-frame is dropped; first frame completes intact.
      clear_mon();
      model_frame(48'h001122334455, 32'hC0A80002, LMAC, LIP);
      send_req(16'h0001, 1'b1, 48'h001122334455, 32'hC0A80002, LIP);
      repeat (10) @(posedge clk);
      send_req(16'h0001, 1'b1, 48'h665544332211, 32'hC0A80007, LIP);
      exp_drops++;
      wait_frame(0);
      check_frame("drop1");
      repeat (20) @(negedge clk);
      check("drop1_no_second", got_q.size(), EXP_LEN);
      check("drop1_count", {56'd0, drop_count}, exp_drops);

      // Hold triggers for 300 cycles against a stalled sink: counter saturates.
      clear_mon();
      model_frame(48'h0A0B0C0D0E0F, 32'hC0A800FE, LMAC, LIP);
      @(posedge clk); #1;
      tx_ready = 0;
      operation = 16'h0001; decode_valid = 1;
      sender_hardware_address = 48'h0A0B0C0D0E0F;
      sender_protocol_address = 32'hC0A800FE;
      target_protocol_address = LIP;
      arp_done = 1;
      repeat (300) @(posedge clk);
      #1;
      arp_done = 0;
      exp_drops = (exp_drops + 299 > 255) ? 255 : exp_drops + 299;
      check("sat_count", {56'd0, drop_count}, exp_drops);
      wait_frame(0);
      check_frame("sat");
      check("sat_count_after", {56'd0, drop_count}, exp_drops);

      // Reset while byte 20 is on the bus, then a fresh full frame.
      clear_mon();
      model_frame(48'h001122334455, 32'hC0A80002, LMAC, LIP);
      send_req(16'h0001, 1'b1, 48'h001122334455, 32'hC0A80002, LIP);
      repeat (21) @(posedge clk);
      #1;
      sync_reset = 1;
      @(negedge clk);
      check("rst_mid_byte20", {56'd0, tx_data}, {56'd0, exp_q[20]});
      @(posedge clk); #1;
      sync_reset = 0;
      exp_drops = 0;
      check("rst_mid_outputs", {60'd0, tx_valid, busy, tx_eop, tx_sop}, 64'd0);
      check("rst_mid_drop", {56'd0, drop_count}, exp_drops);
      clear_mon();
      send_req(16'h0001, 1'b1, 48'h001122334455, 32'hC0A80002, LIP);
      wait_frame(0);
      check_frame("post_rst");

      // Randomized requests against the reference model.
      for (int r = 0; r < 10; r++) begin
         rmac = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
         lmac = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
         rip  = $urandom;
         lip  = $urandom;
         kind = $urandom_range(0, 3);
         local_mac = lmac;
         local_ip  = lip;
         clear_mon();
         model_frame(rmac, rip, lmac, lip);
         case (kind)
            1: send_req(16'h0001, 1'b1, rmac, rip, lip ^ 32'h00000100);
            2: send_req(16'h0002, 1'b1, rmac, rip, lip);
            default: send_req(16'h0001, 1'b1, rmac, rip, lip);
         endcase
         local_mac = ~lmac;
         local_ip  = ~lip;
         if (kind == 1 || kind == 2) begin
            repeat (70) @(negedge clk);
            check($sformatf("rnd%0d_no_valid", r), vcount, 64'd0);
         end else begin
            wait_frame(1);
            check_frame($sformatf("rnd%0d", r));
         end
         check($sformatf("rnd%0d_drop", r), {56'd0, drop_count}, exp_drops);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
